// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD line responder: receives 48-bit host commands, validates them and
// returns a CRC7-protected short or long response, optionally holding DAT0 busy.
module sd_cmd_responder #(
    parameter int N_CR        = 5,
    parameter int RSP_TIMEOUT = 60,
    parameter int BUSY_W      = 16
) (
    input  logic              sd_clk_i,
    input  logic              rst_ni,
    input  logic              cmd_i,
    output logic              cmd_o,
    output logic              cmd_en_o,
    output logic              dat0_busy_o,
    output logic              cmd_valid_o,
    output logic              cmd_err_o,
    output logic              crc_err_o,
    output logic              end_bit_err_o,
    output logic [5:0]        cmd_index_o,
    output logic [31:0]       cmd_arg_o,
    output logic              rsp_ready_o,
    input  logic              rsp_valid_i,
    input  logic [1:0]        rsp_type_i,
    input  logic [119:0]      rsp_data_i,
    input  logic [BUSY_W-1:0] rsp_busy_cycles_i,
    output logic              rsp_miss_o
);

    localparam int CW = $clog2(RSP_TIMEOUT + N_CR + 2) + 1;

    localparam logic [CW-1:0] CYC_FIRST   = CW'(2);
    localparam logic [CW-1:0] CYC_TX_GO   = CW'(N_CR - 1);
    localparam logic [CW-1:0] CYC_TIMEOUT = CW'(RSP_TIMEOUT);

    localparam logic [5:0] RX_LAST    = 6'd47;
    localparam logic [5:0] RX_CRC_END = 6'd40;

    localparam logic [7:0] SHORT_DATA_END = 8'd40;
    localparam logic [7:0] LONG_DATA_END  = 8'd128;
    localparam logic [7:0] SHORT_LAST     = 8'd47;
    localparam logic [7:0] LONG_LAST      = 8'd135;
    localparam logic [7:0] LONG_CRC_FROM  = 8'd8;

    localparam logic [1:0] RSP_NONE       = 2'b00;
    localparam logic [1:0] RSP_LONG       = 2'b01;
    localparam logic [1:0] RSP_SHORT_BUSY = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RX,
        CHECK,
        WAIT_RSP,
        TX,
        BUSY
    } state_e;

    state_e              state_q, state_d;
    logic [46:0]         shift_q, shift_d;
    logic [5:0]          rx_cnt_q, rx_cnt_d;
    logic [6:0]          crc_q, crc_d;
    logic [5:0]          idx_q, idx_d;
    logic [31:0]         arg_q, arg_d;
    logic [CW-1:0]       cyc_q, cyc_d;
    logic                have_q, have_d;
    logic                rsp_long_q, rsp_long_d;
    logic [119:0]        rsp_data_q, rsp_data_d;
    logic [135:0]        tx_sr_q, tx_sr_d;
    logic [7:0]          tx_cnt_q, tx_cnt_d;
    logic [BUSY_W-1:0]   busy_cnt_q, busy_cnt_d;

    logic                hs;
    logic                desc_long;
    logic [119:0]        desc_data;
    logic                tx_bit;
    logic                crc_bad;
    logic                frame_bits_bad;
    logic [7:0]          tx_data_end;
    logic [7:0]          tx_crc_from;
    logic [7:0]          tx_last;

    // Serial CRC7 (x^7 + x^3 + 1), MSB first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = crc[6] ^ b;
        return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    // After the end bit, shift_q holds frame bits 46..0 (the start bit is implicit).
    assign crc_bad        = (shift_q[7:1] != crc_q);
    assign frame_bits_bad = ~shift_q[46] | ~shift_q[0];

    assign tx_data_end = rsp_long_q ? LONG_DATA_END : SHORT_DATA_END;
    assign tx_crc_from = rsp_long_q ? LONG_CRC_FROM : 8'd0;
    assign tx_last     = rsp_long_q ? LONG_LAST : SHORT_LAST;

    assign cmd_index_o = idx_q;
    assign cmd_arg_o   = arg_q;

    always_ff @(posedge sd_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            rx_cnt_q   <= '0;
            crc_q      <= '0;
            idx_q      <= '0;
            arg_q      <= '0;
            cyc_q      <= '0;
            have_q     <= 1'b0;
            rsp_long_q <= 1'b0;
            rsp_data_q <= '0;
            tx_sr_q    <= '0;
            tx_cnt_q   <= '0;
            busy_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            rx_cnt_q   <= rx_cnt_d;
            crc_q      <= crc_d;
            idx_q      <= idx_d;
            arg_q      <= arg_d;
            cyc_q      <= cyc_d;
            have_q     <= have_d;
            rsp_long_q <= rsp_long_d;
            rsp_data_q <= rsp_data_d;
            tx_sr_q    <= tx_sr_d;
            tx_cnt_q   <= tx_cnt_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        rx_cnt_d   = rx_cnt_q;
        crc_d      = crc_q;
        idx_d      = idx_q;
        arg_d      = arg_q;
        cyc_d      = cyc_q;
        have_d     = have_q;
        rsp_long_d = rsp_long_q;
        rsp_data_d = rsp_data_q;
        tx_sr_d    = tx_sr_q;
        tx_cnt_d   = tx_cnt_q;
        busy_cnt_d = busy_cnt_q;

        cmd_o         = 1'b1;
        cmd_en_o      = 1'b0;
        dat0_busy_o   = 1'b0;
        cmd_valid_o   = 1'b0;
        cmd_err_o     = 1'b0;
        crc_err_o     = 1'b0;
        end_bit_err_o = 1'b0;
        rsp_ready_o   = 1'b0;
        rsp_miss_o    = 1'b0;
        hs            = 1'b0;
        desc_long     = rsp_long_q;
        desc_data     = rsp_data_q;
        tx_bit        = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (!cmd_i) begin
                    state_d  = RX;
                    rx_cnt_d = 6'd1;
                    crc_d    = '0;
                end
            end

            RX: begin
                shift_d  = {shift_q[45:0], cmd_i};
                rx_cnt_d = rx_cnt_q + 6'd1;
                if (rx_cnt_q < RX_CRC_END) begin
                    crc_d = crc7_step(crc_q, cmd_i);
                end
                if (rx_cnt_q == RX_LAST) begin
                    // Frame bit k sits at shift_q[k-1] until the end bit shifts in.
                    idx_d   = shift_q[44:39];
                    arg_d   = shift_q[38:7];
                    state_d = CHECK;
                end
            end

            CHECK: begin
                crc_err_o     = crc_bad;
                end_bit_err_o = frame_bits_bad;
                if (crc_bad || frame_bits_bad) begin
                    cmd_err_o = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cmd_valid_o = 1'b1;
                    cyc_d       = CYC_FIRST;
                    have_d      = 1'b0;
                    state_d     = WAIT_RSP;
                end
            end

            WAIT_RSP: begin
                cyc_d = cyc_q + CW'(1);
                if (!have_q && (cyc_q == CYC_TIMEOUT)) begin
                    rsp_miss_o = 1'b1;
                    state_d    = IDLE;
                end else begin
                    rsp_ready_o = ~have_q;
                    hs          = rsp_ready_o & rsp_valid_i;
                    if (hs) begin
                        desc_long  = (rsp_type_i == RSP_LONG);
                        desc_data  = rsp_data_i;
                        rsp_long_d = desc_long;
                        rsp_data_d = rsp_data_i;
                        busy_cnt_d = (rsp_type_i == RSP_SHORT_BUSY) ? rsp_busy_cycles_i : '0;
                        have_d     = 1'b1;
                    end
                    if (hs && (rsp_type_i == RSP_NONE)) begin
                        state_d = IDLE;
                    end else if ((have_q || hs) && (cyc_q >= CYC_TX_GO)) begin
                        state_d  = TX;
                        tx_cnt_d = '0;
                        crc_d    = '0;
                        if (desc_long) begin
                            tx_sr_d = {2'b00, 6'h3F, desc_data, 8'h00};
                        end else begin
                            tx_sr_d = {2'b00, idx_q, desc_data[31:0], 96'h0};
                        end
                    end
                end
            end

            TX: begin
                cmd_en_o = 1'b1;
                if (tx_cnt_q < tx_data_end) begin
                    tx_bit = tx_sr_q[135];
                    if (tx_cnt_q >= tx_crc_from) begin
                        crc_d = crc7_step(crc_q, tx_bit);
                    end
                end else if (tx_cnt_q < (tx_data_end + 8'd7)) begin
                    tx_bit = crc_q[6];
                    crc_d  = {crc_q[5:0], 1'b0};
                end
                cmd_o    = tx_bit;
                tx_sr_d  = {tx_sr_q[134:0], 1'b0};
                tx_cnt_d = tx_cnt_q + 8'd1;
                if (tx_cnt_q == tx_last) begin
                    state_d = (busy_cnt_q != '0) ? BUSY : IDLE;
                end
            end

            BUSY: begin
                dat0_busy_o = 1'b1;
                busy_cnt_d  = busy_cnt_q - BUSY_W'(1);
                if (busy_cnt_q <= BUSY_W'(1)) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Randomized bench for sd_cmd_responder: frames are built and responses predicted from
// CRC7 polynomial division and cycle arithmetic, then compared per transaction.
module tb_sd_cmd_responder;

    localparam int N_CR        = 5;
    localparam int RSP_TIMEOUT = 60;
    localparam int BUSY_W      = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_i;
    logic              cmd_o;
    logic              cmd_en_o;
    logic              dat0_busy_o;
    logic              cmd_valid_o;
    logic              cmd_err_o;
    logic              crc_err_o;
    logic              end_bit_err_o;
    logic [5:0]        cmd_index_o;
    logic [31:0]       cmd_arg_o;
    logic              rsp_ready_o;
    logic              rsp_valid_i;
    logic [1:0]        rsp_type_i;
    logic [119:0]      rsp_data_i;
    logic [BUSY_W-1:0] rsp_busy_cycles_i;
    logic              rsp_miss_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    sd_cmd_responder #(
        .N_CR        (N_CR),
        .RSP_TIMEOUT (RSP_TIMEOUT),
        .BUSY_W      (BUSY_W)
    ) dut (
        .sd_clk_i          (clk),
        .rst_ni            (rst_n),
        .cmd_i             (cmd_i),
        .cmd_o             (cmd_o),
        .cmd_en_o          (cmd_en_o),
        .dat0_busy_o       (dat0_busy_o),
        .cmd_valid_o       (cmd_valid_o),
        .cmd_err_o         (cmd_err_o),
        .crc_err_o         (crc_err_o),
        .end_bit_err_o     (end_bit_err_o),
        .cmd_index_o       (cmd_index_o),
        .cmd_arg_o         (cmd_arg_o),
        .rsp_ready_o       (rsp_ready_o),
        .rsp_valid_i       (rsp_valid_i),
        .rsp_type_i        (rsp_type_i),
        .rsp_data_i        (rsp_data_i),
        .rsp_busy_cycles_i (rsp_busy_cycles_i),
        .rsp_miss_o        (rsp_miss_o)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1 (n message bits, right-aligned).
    function automatic logic [6:0] crc7_div(input logic [135:0] msg, input int n);
        logic [142:0] v;
        v = {msg, 7'b0};
        for (int i = n + 6; i >= 7; i--) begin
            if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
        end
        return v[6:0];
    endfunction

    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            @(negedge clk);
            cmd_i = f[i];
        end
    endtask

    // kind: 0 good, 1 corrupted CRC bit, 2 end bit 0, 3 transmission bit 0. h: handshake cycle, 0 = never.
    task automatic do_txn(input logic [5:0] idx, input logic [31:0] arg, input int kind,
                          input logic [1:0] typ, input logic [119:0] data, input int busy, input int h);
        logic [39:0]  msg40;
        logic [47:0]  frame;
        logic [3:0]   exp_flags;
        logic [135:0] exp_bits, obs_bits;
        logic [6:0]   rcrc;
        bit           good;
        int exp_start, exp_len, exp_busy, exp_busy_first, exp_ready, exp_miss, last;
        int obs_start, obs_len, obs_busy, obs_busy_first, obs_ready, obs_miss, obs_miss_n, strays;

        good  = (kind == 0);
        msg40 = {(kind == 3) ? 2'b00 : 2'b01, idx, arg};
        frame = {msg40, crc7_div(136'(msg40), 40), 1'b1};
        if (kind == 1) frame[$urandom_range(1, 7)] ^= 1'b1;
        if (kind == 2) frame[0] = 1'b0;
        case (kind)
            0:       exp_flags = 4'b1000;
            1:       exp_flags = 4'b0110;
            default: exp_flags = 4'b0101;
        endcase

        rsp_type_i        = typ;
        rsp_data_i        = data;
        rsp_busy_cycles_i = BUSY_W'(busy);
        rsp_valid_i       = 1'b0;

        exp_start = 0; exp_len = 0; exp_bits = '0; exp_busy = 0; exp_busy_first = 0;
        exp_ready = 0; exp_miss = 0; last = 6;
        if (good && h == 0) begin
            exp_ready = RSP_TIMEOUT - 2;
            exp_miss  = RSP_TIMEOUT;
            last      = RSP_TIMEOUT;
        end else if (good) begin
            exp_ready = h - 1;
            last      = h;
            if (typ != 2'b00) begin
                exp_start = (h + 1 > N_CR) ? h + 1 : N_CR;
                if (typ == 2'b01) begin
                    rcrc     = crc7_div(136'(data), 120);
                    exp_bits = {2'b00, 6'h3F, data, rcrc, 1'b1};
                    exp_len  = 136;
                end else begin
                    rcrc     = crc7_div(136'({2'b00, idx, data[31:0]}), 40);
                    exp_bits = 136'({2'b00, idx, data[31:0], rcrc, 1'b1});
                    exp_len  = 48;
                end
                last = exp_start + exp_len - 1;
                if (typ == 2'b11 && busy > 0) begin
                    exp_busy       = busy;
                    exp_busy_first = last + 1;
                    last           = last + busy;
                end
            end
        end

        send_frame(frame);
        @(negedge clk);
        cmd_i = 1'b1;
        check_val("rx_flags", 136'({cmd_valid_o, cmd_err_o, crc_err_o, end_bit_err_o}), 136'(exp_flags));
        check_val("rx_idx_arg", 136'({cmd_index_o, cmd_arg_o}), 136'({idx, arg}));

        obs_start = 0; obs_len = 0; obs_bits = '0; obs_busy = 0; obs_busy_first = 0;
        obs_ready = 0; obs_miss = 0; obs_miss_n = 0; strays = 0;
        for (int c = 2; c <= last + 2; c++) begin
            @(negedge clk);
            rsp_valid_i = good && (c == h);
            if (rsp_ready_o) obs_ready++;
            if (rsp_miss_o) begin obs_miss = c; obs_miss_n++; end
            if (cmd_valid_o || cmd_err_o || (!cmd_en_o && !cmd_o)) strays++;
            if (cmd_en_o) begin
                if (obs_len == 0) obs_start = c;
                obs_len++;
                obs_bits = {obs_bits[134:0], cmd_o};
            end
            if (dat0_busy_o) begin
                if (obs_busy == 0) obs_busy_first = c;
                obs_busy++;
            end
        end
        rsp_valid_i = 1'b0;

        check_val("rsp_start", 136'(obs_start), 136'(exp_start));
        check_val("rsp_len", 136'(obs_len), 136'(exp_len));
        check_val("rsp_bits", obs_bits, exp_bits);
        check_val("busy_len", 136'(obs_busy), 136'(exp_busy));
        check_val("busy_first", 136'(obs_busy_first), 136'(exp_busy_first));
        check_val("ready_cycles", 136'(obs_ready), 136'(exp_ready));
        check_val("miss_cycle", 136'(obs_miss), 136'(exp_miss));
        check_val("miss_count", 136'(obs_miss_n), 136'((exp_miss != 0) ? 1 : 0));
        check_val("stray_pulses", 136'(strays), 136'(0));
        check_val("idle_after", 136'({cmd_en_o, cmd_o, dat0_busy_o}), 136'(3'b010));

        n_txn++;
        $display("txn %0d: idx=%0d arg=%h kind=%0d type=%0d h=%0d busy=%0d start=%0d len=%0d",
                 n_txn, idx, arg, kind, typ, h, busy, obs_start, obs_len);
    endtask

    task automatic reset_mid_tx;
        logic [39:0] msg40;
        msg40 = {2'b01, 6'd17, 32'h0000_2000};
        rsp_type_i  = 2'b10;
        rsp_data_i  = 120'h0900;
        rsp_valid_i = 1'b0;
        send_frame({msg40, crc7_div(136'(msg40), 40), 1'b1});
        @(negedge clk);
        cmd_i = 1'b1;
        for (int c = 2; c <= 12; c++) begin
            @(negedge clk);
            rsp_valid_i = (c == 2);
        end
        check_val("pre_reset_tx", 136'(cmd_en_o), 136'(1));
        rst_n = 1'b0;
        #1;
        check_val("reset_mid_tx_drive", 136'({cmd_en_o, cmd_o, dat0_busy_o}), 136'(3'b010));
        check_val("reset_mid_tx_regs", 136'({rsp_ready_o, cmd_index_o, cmd_arg_o}), 136'(0));
        rsp_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn reset: asserted rst_ni during TX");
    endtask

    initial begin
        logic [119:0] rdata;
        int           r, kind, h;

        rst_n             = 1'b0;
        cmd_i             = 1'b1;
        rsp_valid_i       = 1'b0;
        rsp_type_i        = 2'b00;
        rsp_data_i        = '0;
        rsp_busy_cycles_i = '0;
        #12;
        check_val("reset_state",
                  136'({cmd_o, cmd_en_o, dat0_busy_o, cmd_valid_o, cmd_err_o, rsp_ready_o, rsp_miss_o}),
                  136'(7'b1000000));
        check_val("reset_idx_arg", 136'({cmd_index_o, cmd_arg_o}), 136'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_txn(6'd0, 32'h0, 0, 2'b00, 120'h0, 0, 2);
        do_txn(6'd17, 32'h0000_1000, 0, 2'b10, 120'h0000_0900, 0, 2);
        do_txn(6'd2, 32'h0, 0, 2'b01, 120'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DE, 0, 3);
        do_txn(6'd17, 32'h0000_1000, 1, 2'b10, 120'h0, 0, 2);
        do_txn(6'd17, 32'h0000_1000, 2, 2'b10, 120'h0, 0, 2);
        do_txn(6'd24, 32'hDEAD_BEEF, 3, 2'b10, 120'h0, 0, 2);
        do_txn(6'd7, 32'h1234_0000, 0, 2'b11, 120'h0000_0700, 10, 2);
        do_txn(6'd7, 32'h1234_0000, 0, 2'b11, 120'h0, 0, 0);
        do_txn(6'd12, 32'h0, 0, 2'b11, 120'h0000_0800, 0, 9);
        reset_mid_tx();
        do_txn(6'd13, 32'hABCD_0000, 0, 2'b10, 120'h0000_0900, 0, 4);

        for (int i = 0; i < 30; i++) begin
            r     = $urandom_range(0, 9);
            kind  = (r <= 6) ? 0 : r - 6;
            h     = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(2, 14);
            rdata = {$urandom, $urandom, $urandom, $urandom};
            do_txn(6'($urandom), 32'($urandom), kind, 2'($urandom), rdata, $urandom_range(0, 20), h);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
